// File: rtl/stb_sampler.sv
// -----------------------------------------------------------------------------
// stb_sampler
//
// Strobe-driven comparator sampler for the measure unit. For each of N strobes
// it requests a strobe from the upstream strobe generator, waits for that strobe
// to complete, then samples the synchronized comparator a programmable number
// of cycles later. Hits (comparator = 1) and completed samples are counted and
// reported with a one-cycle done pulse. A stalled generator is caught by a
// per-request timeout, which aborts the run with a sticky error flag.
//
// Parameters
//   TIMEOUT    maximum cycles spent waiting on the generator per request
//   CNT_WIDTH  width of the sample-count, hit-count and completed-sample regs
//
// Ports
//   clk_i           in   system clock
//   rst_i           in   synchronous active-high reset
//   start_i         in   single-cycle start command (honoured only when idle)
//   n_samples_i     in   number of strobes to sample, latched on start
//   sample_delay_i  in   cycles from strobe end to sample point, latched on start
//   gen_rdy_i       in   strobe generator has locked its period
//   stb_valid_i     in   generator valid: falls after a request, rises at strobe end
//   stb_req_o       out  strobe request (rising edge is the request)
//   cmp_i           in   asynchronous comparator output
//   busy_o          out  run in progress
//   done_o          out  one-cycle pulse at end of run (success or abort)
//   err_o           out  sticky abort flag, cleared on the next accepted start
//   hits_o          out  samples that saw the synchronized comparator high
//   samples_o       out  samples completed
// -----------------------------------------------------------------------------
module stb_sampler #(
  parameter int unsigned TIMEOUT   = 1048576,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] n_samples_i,
  input  logic [7:0]           sample_delay_i,
  input  logic                 gen_rdy_i,
  input  logic                 stb_valid_i,
  output logic                 stb_req_o,
  input  logic                 cmp_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [CNT_WIDTH-1:0] hits_o,
  output logic [CNT_WIDTH-1:0] samples_o
);

  // The timeout counter only ever has to reach TIMEOUT-1.
  localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHECK     = 3'd1,
    REQ       = 3'd2,
    WAIT_FALL = 3'd3,
    WAIT_RISE = 3'd4,
    DELAY     = 3'd5,
    SAMPLE    = 3'd6,
    DONE      = 3'd7
  } state_t;

  state_t               state_q;
  state_t               state_nxt;

  // Control
  logic                 req_cnt_q;   // 0 in first REQ cycle, 1 in second
  logic                 abort_err;   // current transition ends the run with an error
  logic                 tmo_hit;
  logic                 start_acc;

  // Latched run configuration and working counters
  logic [CNT_WIDTH-1:0] n_q;
  logic [7:0]           dly_q;
  logic [7:0]           dcnt_q;
  logic [TMO_W-1:0]     tmo_q;

  // Comparator synchronizer
  logic                 cmp_p0;
  logic                 cmp_p1;

  assign start_acc = (state_q == IDLE) && start_i;
  assign tmo_hit   = (tmo_q == TMO_LAST);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state_q;
    abort_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) state_nxt = CHECK;
      end
      CHECK: begin
        // An empty run finishes cleanly even if the generator is not ready.
        if (n_q == '0) begin
          state_nxt = DONE;
        end else if (!gen_rdy_i) begin
          state_nxt = DONE;
          abort_err = 1'b1;
        end else begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (req_cnt_q) state_nxt = WAIT_FALL;
      end
      WAIT_FALL: begin
        if (tmo_hit) begin
          state_nxt = DONE;
          abort_err = 1'b1;
        end else if (!stb_valid_i) begin
          state_nxt = WAIT_RISE;
        end
      end
      WAIT_RISE: begin
        if (tmo_hit) begin
          state_nxt = DONE;
          abort_err = 1'b1;
        end else if (stb_valid_i) begin
          state_nxt = DELAY;
        end
      end
      DELAY: begin
        if (dcnt_q == 8'd0) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        // samples_o still holds the pre-increment count in this cycle.
        if ((samples_o + CNT_WIDTH'(1)) == n_q) state_nxt = DONE;
        else                                    state_nxt = REQ;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register, registered outputs and synchronizer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      req_cnt_q <= 1'b0;
      stb_req_o <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      hits_o    <= '0;
      samples_o <= '0;
      cmp_p0    <= 1'b0;
      cmp_p1    <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cmp_p0    <= cmp_i;
      cmp_p1    <= cmp_p0;

      // Request is high exactly while in REQ: one rising edge per request.
      stb_req_o <= (state_nxt == REQ);
      req_cnt_q <= (state_q == REQ) && !req_cnt_q;

      done_o    <= (state_q == DONE);

      if (start_acc) begin
        busy_o    <= 1'b1;
        err_o     <= 1'b0;
        hits_o    <= '0;
        samples_o <= '0;
      end else if (state_q == DONE) begin
        busy_o    <= 1'b0;
      end

      if (abort_err) err_o <= 1'b1;

      if (state_q == SAMPLE) begin
        samples_o <= samples_o + CNT_WIDTH'(1);
        hits_o    <= hits_o + CNT_WIDTH'(cmp_p1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Configuration latch and working counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (start_acc) begin
      n_q   <= n_samples_i;
      dly_q <= sample_delay_i;
    end

    // Timeout window restarts with every request.
    if ((state_nxt == REQ) && (state_q != REQ)) begin
      tmo_q <= '0;
    end else if ((state_q == WAIT_FALL) || (state_q == WAIT_RISE)) begin
      tmo_q <= tmo_q + TMO_W'(1);
    end

    if ((state_q == WAIT_RISE) && (state_nxt == DELAY)) begin
      dcnt_q <= dly_q;
    end else if ((state_q == DELAY) && (dcnt_q != 8'd0)) begin
      dcnt_q <= dcnt_q - 8'd1;
    end
  end

endmodule

// File: tb/tb_stb_sampler.sv
module tb_stb_sampler;

  localparam int CW  = 16;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] n_in;
  logic [7:0]    dly_in;
  logic          gen_rdy;
  logic          stb_valid;
  logic          stb_req;
  logic          cmp;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] hits;
  logic [CW-1:0] samples;

  always #5 clk = ~clk;

  stb_sampler #(.TIMEOUT(TMO), .CNT_WIDTH(CW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .n_samples_i    (n_in),
    .sample_delay_i (dly_in),
    .gen_rdy_i      (gen_rdy),
    .stb_valid_i    (stb_valid),
    .stb_req_o      (stb_req),
    .cmp_i          (cmp),
    .busy_o         (busy),
    .done_o         (done),
    .err_o          (err),
    .hits_o         (hits),
    .samples_o      (samples)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Generator / comparator model configuration (written by the main sequence)
  int gen_period  = 40;
  int stuck_after = 0;   // 0: never stick; k: valid stays high from request k+1 on
  int cmp_mode    = 0;   // 0 random, 1 constant 1, 2 toggle starting at 0
  int req_base    = 0;

  // Generator / comparator model state (written only by the model)
  int gen_cnt  = 0;
  int req_idx  = 0;
  int req3_cyc = 0;
  int cmp_q[$];
  bit req_prev = 1'b0;

  // Done-pulse monitor
  int done_cnt = 0;
  int done_cyc = 0;

  // Strobe generator: valid falls on each request edge and rises gen_period
  // cycles later. Each strobe gets one comparator level held for the whole
  // strobe, recorded so the expected hit count is just a sum.
  initial begin
    forever begin
      @(negedge clk);
      if (stb_req && !req_prev) begin
        int k;
        req_idx++;
        k = req_idx - req_base;
        case (cmp_mode)
          1:       cmp = 1'b1;
          2:       cmp = (k % 2 == 0);
          default: cmp = 1'($urandom_range(0, 1));
        endcase
        cmp_q.push_back(int'(cmp));
        if (k == 3) req3_cyc = cyc;
        if (stuck_after == 0 || k <= stuck_after) begin
          stb_valid = 1'b0;
          gen_cnt   = gen_period;
        end
      end else if (gen_cnt > 0) begin
        gen_cnt--;
        if (gen_cnt == 0) stb_valid = 1'b1;
      end
      req_prev = stb_req;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sum_hits(input int base, input int ns);
    int s = 0;
    for (int i = 0; i < ns && (base + i) < cmp_q.size(); i++) s += cmp_q[base + i];
    return s;
  endfunction

  // One complete run: start, wait (bounded) for done, compare against the model.
  task automatic run(input string tag, input int n, input int d, input int mode,
                     input int period, input int stuck, input int poke,
                     input int exp_samples, input int exp_reqs, input bit exp_err);
    int  q_base;
    int  d_base;
    bit  seen;
    int  budget;
    @(negedge clk);
    cmp_mode    = mode;
    gen_period  = period;
    stuck_after = stuck;
    req_base    = req_idx;
    q_base      = cmp_q.size();
    d_base      = done_cnt;
    start       = 1'b1;
    n_in        = CW'(n);
    dly_in      = 8'(d);
    @(negedge clk);
    start  = 1'b0;
    n_in   = CW'($urandom);
    dly_in = 8'($urandom);
    check({tag, ".busy_after_start"}, busy, 1);
    check({tag, ".err_cleared"}, err, 0);
    seen   = 1'b0;
    budget = (n + 2) * 120 + 200;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (poke != 0 && i == poke) begin
        start = 1'b1;
        n_in  = CW'(1);
      end else begin
        start = 1'b0;
      end
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check({tag, ".done_seen"}, seen, 1);
    check({tag, ".busy_at_done"}, busy, 0);
    check({tag, ".samples"}, samples, exp_samples);
    check({tag, ".hits"}, hits, sum_hits(q_base, exp_samples));
    check({tag, ".err"}, err, exp_err);
    check({tag, ".req_edges"}, req_idx - req_base, exp_reqs);
    @(negedge clk);
    check({tag, ".done_one_cycle"}, done, 0);
    check({tag, ".done_count"}, done_cnt - d_base, 1);
  endtask

  initial begin
    int n;
    int d;
    int base;
    int d_base;
    bit found;

    rst       = 1'b1;
    start     = 1'b0;
    n_in      = '0;
    dly_in    = '0;
    gen_rdy   = 1'b1;
    stb_valid = 1'b1;
    cmp       = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.err", err, 0);
    check("rst.req", stb_req, 0);
    check("rst.hits", hits, 0);
    check("rst.samples", samples, 0);
    rst = 1'b0;

    // Basic runs from the test plan
    run("n4_ones", 4, 3, 1, 40, 0, 0, 4, 4, 1'b0);
    run("n6_toggle", 6, 3, 2, 40, 0, 0, 6, 6, 1'b0);

    // n = 0: done in the cycle after edge 2, no request
    @(negedge clk);
    base   = req_idx;
    d_base = done_cnt;
    start  = 1'b1;
    n_in   = '0;
    dly_in = 8'd5;
    @(negedge clk);
    start = 1'b0;
    check("n0.busy_edge0", busy, 1);
    @(negedge clk);
    check("n0.done_edge1", done, 0);
    @(negedge clk);
    check("n0.done_edge2", done, 1);
    check("n0.busy_edge2", busy, 0);
    check("n0.err", err, 0);
    check("n0.hits", hits, 0);
    check("n0.samples", samples, 0);
    check("n0.req_edges", req_idx - base, 0);
    @(negedge clk);
    check("n0.done_count", done_cnt - d_base, 1);

    // Generator not ready: abort with error, then a good run clears it
    gen_rdy = 1'b0;
    run("not_rdy", 3, 2, 0, 40, 0, 0, 0, 0, 1'b1);
    gen_rdy = 1'b1;
    run("after_err", 3, 2, 0, 40, 0, 0, 3, 3, 1'b0);

    // Randomized runs
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 8);
      d = $urandom_range(0, 20);
      run($sformatf("rand%0d", r), n, d, 0, $urandom_range(8, 50), 0, 0, n, n, 1'b0);
    end

    // Generator stalls (valid stuck high) after the 2nd sample
    run("timeout", 5, 2, 0, 40, 2, 0, 2, 3, 1'b1);
    check("timeout.latency_in_range",
          ((done_cyc - req3_cyc) >= 60) && ((done_cyc - req3_cyc) <= 72), 1);

    // Start pulsed mid-run is ignored
    run("start_busy", 4, 5, 0, 30, 0, 20, 4, 4, 1'b0);

    // Reset asserted during DELAY of the 2nd strobe
    @(negedge clk);
    cmp_mode    = 0;
    gen_period  = 40;
    stuck_after = 0;
    req_base    = req_idx;
    start       = 1'b1;
    n_in        = CW'(3);
    dly_in      = 8'd20;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if ((req_idx - req_base) == 2 && stb_valid) found = 1'b1;
    end
    check("rstmid.reached_delay", found, 1);
    repeat (4) @(negedge clk);
    check("rstmid.samples_before", samples, 1);
    check("rstmid.busy_before", busy, 1);
    d_base = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid.busy", busy, 0);
    check("rstmid.req", stb_req, 0);
    check("rstmid.done", done, 0);
    check("rstmid.err", err, 0);
    check("rstmid.hits", hits, 0);
    check("rstmid.samples", samples, 0);
    repeat (10) @(negedge clk);
    check("rstmid.no_done", done_cnt - d_base, 0);
    check("rstmid.stays_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
